// File: rtl/router_fifo.sv
// Per-destination packet FIFO of the 1x3 router: header-tagged storage plus a payload down-counter.
// Define ROUTER_FIFO_TRISTATE_EN to release data_out to high impedance when idle (shared bus).
module router_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             write_enb,
    input  logic             soft_reset,
    input  logic             read_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH:0]   mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [5:0]       count;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH:0]   rd_word;
    logic             wr_acc;
    logic             rd_acc;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];

    // Storage is never reset; the pointers alone define which words are valid.
    always_ff @(posedge clock) begin
        if (!resetn && !soft_reset && wr_acc)
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end

`ifdef ROUTER_FIFO_TRISTATE_EN
    logic oe;

    always_ff @(posedge clock) begin
        if (resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_reg <= '0;
            oe       <= 1'b1;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_reg <= '0;
            oe       <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_reg <= rd_word[WIDTH-1:0];
                oe       <= 1'b1;
                // Header length excludes the parity byte, hence the +1.
                if (rd_word[WIDTH])
                    count <= rd_word[7:2] + 6'd1;
                else if (count != 6'd0)
                    count <= count - 6'd1;
            end else if (count == 6'd0) begin
                data_reg <= '0;
                oe       <= 1'b0;
            end
        end
    end

    assign data_out = oe ? data_reg : {WIDTH{1'bz}};
`else
    always_ff @(posedge clock) begin
        if (resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_reg <= '0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_reg <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_reg <= rd_word[WIDTH-1:0];
                // Header length excludes the parity byte, hence the +1.
                if (rd_word[WIDTH])
                    count <= rd_word[7:2] + 6'd1;
                else if (count != 6'd0)
                    count <= count - 6'd1;
            end else if (count == 6'd0) begin
                data_reg <= '0;
            end
        end
    end

    assign data_out = data_reg;
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: reset, fill/drain, wrap, soft reset and reset priority.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       write_enb;
    logic       soft_reset;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pkt [16];
    logic [7:0] idle_val;

    router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .soft_reset (soft_reset),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic lfd);
        write_enb = 1'b1;
        lfd_state = lfd;
        data_in   = d;
        step();
        write_enb = 1'b0;
        lfd_state = 1'b0;
    endtask

    task automatic rd();
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
    endtask

    initial begin
`ifdef ROUTER_FIFO_TRISTATE_EN
        idle_val = 8'hzz;
`else
        idle_val = 8'h00;
`endif
        resetn = 1'b0; write_enb = 1'b0; soft_reset = 1'b0;
        read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
        #1;

        // Reset
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        check("rst_empty", 16'(empty), 16'h1);
        check("rst_full", 16'(full), 16'h0);
        check("rst_dout", 16'(data_out), 16'h00);
        check("rst_count", 16'(dut.count), 16'h0);

        // Fill one packet: header 0x39 (len 14), payload, parity
        pkt[0] = 8'h39;
        for (int i = 1; i < 15; i++) pkt[i] = 8'(8'h10 + 8'(i * 7));
        pkt[15] = 8'h00;
        for (int i = 0; i < 15; i++) pkt[15] = pkt[15] ^ pkt[i];
        for (int i = 0; i < 16; i++) wr(pkt[i], i == 0);
        check("fill_full", 16'(full), 16'h1);
        check("fill_empty", 16'(empty), 16'h0);
        wr(8'hEE, 1'b1);
        check("drop_full", 16'(full), 16'h1);
        check("drop_wrptr", 16'(dut.wr_ptr), 16'd16);

        // Drain the packet
        for (int i = 0; i < 16; i++) begin
            read_enb = 1'b1;
            step();
            check($sformatf("drain_d%0d", i), 16'(data_out), 16'(pkt[i]));
            check($sformatf("drain_c%0d", i), 16'(dut.count), 16'(15 - i));
        end
        read_enb = 1'b0;
        check("drain_empty", 16'(empty), 16'h1);
        rd();
        check("extra_dout", 16'(data_out), 16'(idle_val));
        check("extra_rdptr", 16'(dut.rd_ptr), 16'd16);

        // Wrap with simultaneous read/write at constant occupancy of 8
        for (int i = 0; i < 8; i++) wr(8'(8'hA0 + i), 1'b0);
        write_enb = 1'b1;
        read_enb  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'(8'hB0 + k);
            step();
            check($sformatf("wrap_d%0d", k), 16'(data_out),
                  (k < 8) ? 16'(8'hA0 + k) : 16'(8'hB0 + k - 8));
        end
        write_enb = 1'b0;
        read_enb  = 1'b0;
        check("wrap_wrptr", 16'(dut.wr_ptr), 16'd12);
        check("wrap_rdptr", 16'(dut.rd_ptr), 16'd4);
        check("wrap_empty", 16'(empty), 16'h0);

        // Fill to full, then read+write together: read wins
        for (int i = 0; i < 8; i++) wr(8'(8'hC0 + i), 1'b0);
        check("wfull_full", 16'(full), 16'h1);
        write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hDD;
        step();
        write_enb = 1'b0; read_enb = 1'b0;
        check("rw_full_dout", 16'(data_out), 16'h00BC);
        check("rw_full_full", 16'(full), 16'h0);
        check("rw_full_wrptr", 16'(dut.wr_ptr), 16'd20);
        check("rw_full_rdptr", 16'(dut.rd_ptr), 16'd5);

        // Soft reset mid-packet, with write and read also asserted
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        wr(8'h0D, 1'b1);
        for (int i = 0; i < 4; i++) wr(8'(8'h50 + i), 1'b0);
        soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'h77;
        step();
        soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        check("srst_empty", 16'(empty), 16'h1);
        check("srst_full", 16'(full), 16'h0);
        check("srst_count", 16'(dut.count), 16'h0);
        check("srst_dout", 16'(data_out), 16'(idle_val));
        check("srst_wrptr", 16'(dut.wr_ptr), 16'd0);

        // Next packet after soft reset: header 0x08 (len 2), 0x11, 0x22, parity 0x3B
        wr(8'h08, 1'b1); wr(8'h11, 1'b0); wr(8'h22, 1'b0); wr(8'h3B, 1'b0);
        rd();
        check("pk2_hdr", 16'(data_out), 16'h08);
        check("pk2_cnt0", 16'(dut.count), 16'd3);
        rd();
        check("pk2_p0", 16'(data_out), 16'h11);
        rd();
        check("pk2_p1", 16'(data_out), 16'h22);
        check("pk2_cnt2", 16'(dut.count), 16'd1);
        rd();
        check("pk2_par", 16'(data_out), 16'h3B);
        check("pk2_cnt3", 16'(dut.count), 16'd0);
        step();
        check("pk2_idle", 16'(data_out), 16'(idle_val));

        // Zero-length header: count becomes 1 (parity only)
        wr(8'h01, 1'b1); wr(8'hAA, 1'b0);
        rd();
        check("len0_cnt", 16'(dut.count), 16'd1);
        rd();
        check("len0_par", 16'(data_out), 16'h00AA);
        check("len0_cnt_end", 16'(dut.count), 16'd0);

        // Reset priority over soft_reset and activity
        wr(8'h44, 1'b1); wr(8'h45, 1'b0);
        rd();
        resetn = 1'b1; soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1;
        step();
        resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
        check("prio_empty", 16'(empty), 16'h1);
        check("prio_full", 16'(full), 16'h0);
        check("prio_dout", 16'(data_out), 16'h00);
        check("prio_count", 16'(dut.count), 16'h0);
        check("prio_wrptr", 16'(dut.wr_ptr), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
